// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S capture path.
package i2s_pkg;

    localparam int DATA_W    = 16;          // captured sample width, MSB first
    localparam int SLOT_W    = 32;          // SCK cycles per channel slot
    localparam int PERIOD_W  = 8;           // width of the SCK period control
    localparam int FRAME_W   = 2 * SLOT_W;  // SCK cycles per stereo frame
    localparam int BIT_CNT_W = $clog2(FRAME_W);

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Half-period in clk cycles; never below one, so SCK can never stall.
    function automatic logic [PERIOD_W-1:0] clamp_half(input logic [PERIOD_W-1:0] period);
        logic [PERIOD_W-1:0] half;
        half = period >> 1;
        return (half == '0) ? PERIOD_W'(1) : half;
    endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// I2S bit-clock generator: programmable half-period counter producing SCK
// plus single-cycle rise/fall strobes that coincide with the toggling edge.
module i2s_sck_gen
    import i2s_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [PERIOD_W-1:0] sck_period,
    output logic                sck,
    output logic                rise_evt,
    output logic                fall_evt
);

    logic [PERIOD_W-1:0] half_q;
    logic [PERIOD_W-1:0] half_cnt;
    logic                wrap;

    // half_q only changes at a wrap, so half_cnt never overshoots it.
    assign wrap     = run && (half_cnt == half_q - PERIOD_W'(1));
    assign rise_evt = wrap && !sck;
    assign fall_evt = wrap &&  sck;

    // Half-period counter; the period is re-sampled only at half boundaries.
    always_ff @(posedge clk) begin
        // NOTE: rst_n is synchronous -- it is only looked at inside the clocked
        // block, so it never appears in the sensitivity list.
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge value of its neighbours, independent of statement order.
            sck      <= 1'b0;
            half_cnt <= '0;
            half_q   <= clamp_half(sck_period);
        end else if (wrap) begin
            sck      <= ~sck;
            half_cnt <= '0;
            half_q   <= clamp_half(sck_period);
        end else if (run) begin
            half_cnt <= half_cnt + PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S master receiver for one mono channel: drives SCK/WS, captures the
// left-slot sample MSB-first (one-bit I2S delay) and hands it out on a
// valid/ready port with a sticky overrun flag for dropped samples.
module i2s_rx_deser
    import i2s_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PERIOD_W-1:0] sck_period,
    output logic                sck,
    output logic                ws,
    input  logic                sd,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_vld,
    input  logic                dout_rdy,
    output logic                overrun
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W);

    state_e               state;
    logic                 rise_evt;
    logic                 fall_evt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt_nxt;
    logic                 in_data;
    logic                 load_pend;
    sample_t              shift_q;

    // Mode follows en directly so SCK freezes on the very edge en is seen low.
    assign state = en ? RUN : IDLE;

    i2s_sck_gen u_sck_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (state == RUN),
        .sck_period (sck_period),
        .sck        (sck),
        .rise_evt   (rise_evt),
        .fall_evt   (fall_evt)
    );

    // Counter wraps naturally at FRAME_W because FRAME_W is a power of two.
    assign bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
    // Slot bits 1..DATA_W carry the sample; bit 0 is the I2S delay bit.
    assign in_data     = (bit_cnt != '0) && (bit_cnt <= LAST_BIT);

    // Frame position and word select advance on every falling SCK.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            ws      <= 1'b0;
        end else if (fall_evt) begin
            bit_cnt <= bit_cnt_nxt;
            ws      <= bit_cnt_nxt[BIT_CNT_W-1];
        end
    end

    // Shift in left-slot data on rising SCK; flag completion after the last bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q   <= '0;
            load_pend <= 1'b0;
        end else begin
            load_pend <= rise_evt && (bit_cnt == LAST_BIT);
            if (rise_evt && in_data) begin
                shift_q <= {shift_q[DATA_W-2:0], sd};
            end
        end
    end

    // Output register: a pending word is dropped only if the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            overrun  <= 1'b0;
        end else if (load_pend) begin
            if (dout_vld && !dout_rdy) begin
                overrun <= 1'b1;
            end else begin
                dout     <= shift_q;
                dout_vld <= 1'b1;
            end
        end else if (dout_vld && dout_rdy) begin
            dout_vld <= 1'b0;
        end
    end

endmodule
